tape_sd_adc: RTL

//  Receive-side counterpart of the audio mixer's 1-bit delta-sigma DAC: a first-order sigma-delta ADC
//  for the tape input. External comparator + RC integrator close the loop via fb_out; this block

---
 rtl/tape_sd_adc.sv | 112 +++++++++++
 1 files changed

// File: rtl/tape_sd_adc.sv
// First-order sigma-delta ADC for the tape input: synchronises the comparator, drives the RC feedback
// bit, decimates the bitstream into WIDTH-bit samples and slices a hysteresis tape bit. Optional DC tracker: TAPE_SD_ADC_DCTRACK_EN.
module tape_sd_adc #(
    parameter int WIDTH      = 8,
    parameter int DECIM_LOG2 = 8,
    parameter int HYST       = 16,
    parameter int DC_SHIFT   = 4
) (
    input  logic             clk28,
    input  logic             rst_n,
    input  logic             en,
    input  logic             comp_in,
    output logic             fb_out,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             overload,
    output logic             tape_bit
);

    localparam logic signed [WIDTH+1:0] HYST_W = (WIDTH+2)'(HYST);

    logic [1:0]              sync_reg;
    logic [DECIM_LOG2-1:0]   cnt_reg;
    logic [DECIM_LOG2:0]     acc_reg;
    logic [DECIM_LOG2:0]     acc_next;
    logic [DECIM_LOG2-1:0]   acc_sat;
    logic                    last_cycle;
    logic [WIDTH-1:0]        sample_next;
    logic                    overload_next;
    logic                    tape_next;
    logic signed [WIDTH+1:0] sample_ext;
    logic signed [WIDTH+1:0] centre;
    logic signed [WIDTH+1:0] upper;
    logic signed [WIDTH+1:0] lower;

    assign acc_next      = acc_reg + {{DECIM_LOG2{1'b0}}, fb_out};
    assign last_cycle    = &cnt_reg;
    // A full window of ones reaches 2^DECIM_LOG2, which saturates to the max code.
    assign acc_sat       = acc_next[DECIM_LOG2] ? '1 : acc_next[DECIM_LOG2-1:0];
    assign sample_next   = acc_sat[DECIM_LOG2-1 -: WIDTH];
    assign overload_next = (acc_next == '0) || acc_next[DECIM_LOG2];

`ifdef TAPE_SD_ADC_DCTRACK_EN
    logic [WIDTH+DC_SHIFT-1:0] mean_reg;
    logic [WIDTH+DC_SHIFT-1:0] mean_next;

    assign centre    = signed'({2'b00, mean_reg[WIDTH+DC_SHIFT-1:DC_SHIFT]});
    // The mean never exceeds max_code << DC_SHIFT, so the update cannot wrap.
    assign mean_next = mean_reg + {{DC_SHIFT{1'b0}}, sample_next}
                                - {{DC_SHIFT{1'b0}}, mean_reg[WIDTH+DC_SHIFT-1:DC_SHIFT]};

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            mean_reg <= (WIDTH+DC_SHIFT)'(1) << (WIDTH+DC_SHIFT-1);
        end else if (en && last_cycle) begin
            mean_reg <= mean_next;
        end
    end
`else
    localparam logic signed [WIDTH+1:0] MID_W = (WIDTH+2)'(1 << (WIDTH-1));

    assign centre = MID_W;
`endif

    assign sample_ext = signed'({2'b00, sample_next});
    assign upper      = centre + HYST_W;
    assign lower      = centre - HYST_W;

    // Equality with either band edge holds the previous level.
    always_comb begin
        tape_next = tape_bit;
        if (sample_ext > upper) begin
            tape_next = 1'b1;
        end else if (sample_ext < lower) begin
            tape_next = 1'b0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            fb_out       <= 1'b0;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overload     <= 1'b0;
            tape_bit     <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], comp_in};
            fb_out       <= sync_reg[1] & en;
            sample_valid <= 1'b0;
            if (!en) begin
                // Partial windows are discarded so re-enable always starts clean.
                cnt_reg <= '0;
                acc_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                if (last_cycle) begin
                    acc_reg      <= '0;
                    sample       <= sample_next;
                    overload     <= overload_next;
                    tape_bit     <= tape_next;
                    sample_valid <= 1'b1;
                end else begin
                    acc_reg <= acc_next;
                end
            end
        end
    end

endmodule
